text_vram_arbiter: RTL

- Shares the single-port text VRAM (2 chars per 32-bit word, 80x30 chars, 1200 words) between two requesters: the pixel pipeline's character fetch and the CPU/AXI register bus.
- Display fetches have fixed latency and absolute priority. CPU accesses fill the free port cycles.
- Keeps the display word coherent with CPU writes and drives the BRAM port directly.

---
 rtl/text_vram_pkg.sv | 19 +
 rtl/text_vram_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/text_vram_pkg.sv
// Shared constants and types for the text VRAM port arbiter.
// 80x30 characters, two characters per 32-bit word.
package text_vram_pkg;

  localparam int COLS       = 80;
  localparam int ROWS       = 30;
  localparam int VRAM_WORDS = 1200;
  localparam int ADDR_W     = 11;

  typedef logic [ADDR_W-1:0] vram_addr_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_RD,
    C_ACK
  } cpu_state_t;

endpackage

// File: rtl/text_vram_arbiter.sv
// Single-port text VRAM arbiter: display fetches win the port,
// CPU accesses fill free cycles, CPU writes keep the display word fresh.
module text_vram_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int VRAM_WORDS = 1200,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_active,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_refetch,
  output logic [31:0]       disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  import text_vram_pkg::*;

  cpu_state_t state, state_d;

  logic [ADDR_W-1:0]     last_addr;
  logic                  refetch;
  logic [MEM_RD_LAT-1:0] rd_disp_q;
  logic [MEM_RD_LAT-1:0] rd_cpu_q;

  logic need;
  logic in_range;
  logic disp_go;
  logic cpu_go;
  logic hit;

  assign need = disp_active
              & ((disp_addr != last_addr)
              | refetch
              | disp_refetch);

  assign in_range = cpu_addr < ADDR_W'(VRAM_WORDS);

  assign hit = cpu_go & cpu_we
             & (cpu_addr == last_addr)
             & (|cpu_be);

  always_comb begin
    state_d   = state;
    disp_go   = 1'b0;
    cpu_go    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      disp_go = need;
      unique case (state)
        C_IDLE: begin
          // out-of-range accesses never touch the port
          if (cpu_req) begin
            if (!in_range)
              state_d = cpu_we ? C_ACK : C_RD;
            else if (need)
              state_d = C_WAIT;
            else
              cpu_go = 1'b1;
          end
        end
        C_WAIT: cpu_go = !need;
        C_RD:   state_d = C_ACK;
        C_ACK:  state_d = C_IDLE;
        default: state_d = C_IDLE;
      endcase
      if (disp_go) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (cpu_go) begin
        mem_en    = 1'b1;
        mem_addr  = cpu_addr;
        mem_we    = cpu_we ? cpu_be : 4'h0;
        mem_wdata = cpu_we ? cpu_wdata : 32'h0;
        state_d   = cpu_we ? C_ACK : C_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= C_IDLE;
      last_addr  <= '0;
      refetch    <= 1'b1;
      rd_disp_q  <= '0;
      rd_cpu_q   <= '0;
      disp_rdata <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      state     <= state_d;
      cpu_ack   <= state_d == C_ACK;
      rd_disp_q <= MEM_RD_LAT'({rd_disp_q, disp_go});
      rd_cpu_q  <= MEM_RD_LAT'({rd_cpu_q, cpu_go & ~cpu_we});
      if (disp_go) begin
        last_addr <= disp_addr;
        refetch   <= 1'b0;
      end else if (hit) begin
        refetch <= 1'b1;
      end
      if (rd_disp_q[MEM_RD_LAT-1])
        disp_rdata <= mem_rdata;
      if (state == C_RD)
        cpu_rdata <= rd_cpu_q[MEM_RD_LAT-1] ? mem_rdata : 32'h0;
    end
  end

endmodule
